// File: rtl/int_log_sched_if.sv
// int_log_sched_if: requester, logic-unit and response signals of int_log_sched.
// rsp_err exists only when INT_LOG_SCHED_ERR_EN is defined.
interface int_log_sched_if;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  dp_operation;
    logic [15:0] dp_opa, dp_opb, dp_out;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_data;
`ifdef INT_LOG_SCHED_ERR_EN
    logic        rsp_err;
`endif
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output dp_operation, dp_opa, dp_opb,
        input  dp_out,
        output rsp_valid, rsp_data, rsp_id, busy,
        input  rsp_ready
`ifdef INT_LOG_SCHED_ERR_EN
        , output rsp_err
`endif
    );
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  dp_operation, dp_opa, dp_opb,
        output dp_out,
        input  rsp_valid, rsp_data, rsp_id, busy,
        output rsp_ready
`ifdef INT_LOG_SCHED_ERR_EN
        , input rsp_err
`endif
    );
endinterface

// File: rtl/int_log_sched.sv
// int_log_sched: two-requester round-robin scheduler for a shared 16-bit logic unit of latency LAT.
// Optional INT_LOG_SCHED_ERR_EN: opcode 111 completes with rsp_err=1 and zero data.
module int_log_sched #(
    parameter int LAT = 1
) (
    input logic clk,
    input logic rst,
    int_log_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic        rr, gid, take;
    logic [2:0]  cnt;
    logic [15:0] result;
    // On a tie the round-robin pointer picks; a lone requester always wins.
    assign gid = (bus.req0_valid & bus.req1_valid) ? rr : bus.req1_valid;
    assign take = (state == IDLE) & (bus.req0_valid | bus.req1_valid) & ~rst;
    assign bus.req0_ready = take & ~gid;
    assign bus.req1_ready = take & gid;
    assign bus.busy = state != IDLE;
`ifdef INT_LOG_SCHED_ERR_EN
    assign result = (&bus.dp_operation) ? 16'h0000 : bus.dp_out;
`else
    assign result = bus.dp_out;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr               <= 1'b0;
            cnt              <= 3'd0;
            bus.dp_operation <= 3'd0;
            bus.dp_opa       <= 16'h0000;
            bus.dp_opb       <= 16'h0000;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_data     <= 16'h0000;
            bus.rsp_id       <= 1'b0;
`ifdef INT_LOG_SCHED_ERR_EN
            bus.rsp_err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (take) begin
                    bus.dp_operation <= gid ? bus.req1_op : bus.req0_op;
                    bus.dp_opa       <= gid ? bus.req1_a : bus.req0_a;
                    bus.dp_opb       <= gid ? bus.req1_b : bus.req0_b;
                    bus.rsp_id       <= gid;
                    rr               <= ~gid;
                    cnt              <= LAT[2:0];
                    state            <= WAIT;
                end
                WAIT: if (cnt == 3'd0) begin
                    bus.rsp_data  <= result;
`ifdef INT_LOG_SCHED_ERR_EN
                    bus.rsp_err   <= &bus.dp_operation;
`endif
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_log_sched.sv
// tb_int_log_sched: directed and random stimulus against a cycle-level model with a response scoreboard.
module tb_int_log_sched;
    localparam int LAT = 1;
    typedef struct {logic id; logic [15:0] data; logic err;} rsp_t;
    logic clk = 1'b0, rst = 1'b1;
    int   cyc = 0, total = 0, bad = 0;
    rsp_t exp_q[$];
    logic [15:0] pipe [LAT];
    always #5 clk = ~clk;
    int_log_sched_if bus();
    int_log_sched #(.LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [15:0] lu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: lu = a & b;
            3'd1: lu = ~(a & b);
            3'd2: lu = a | b;
            3'd3: lu = ~(a | b);
            3'd4: lu = a ^ b;
            3'd5: lu = ~(a ^ b);
            3'd6: lu = ~a;
            default: lu = 16'hDEAD ^ a;
        endcase
    endfunction

    function automatic rsp_t want(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        rsp_t r;
        r.id = id;
`ifdef INT_LOG_SCHED_ERR_EN
        r.err = op == 3'd7;
        r.data = r.err ? 16'h0000 : lu(op, a, b);
`else
        r.err = 1'b0;
        r.data = lu(op, a, b);
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Shared logic unit: LAT register stages behind the dp_* operands.
    always @(posedge clk) begin
        pipe[0] <= lu(bus.dp_operation, bus.dp_opa, bus.dp_opb);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.dp_out = pipe[LAT-1];
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: idle flag, acceptance cycle and tie pointer.
    logic m_idle = 1'b1, m_rr = 1'b0, post_rst = 1'b0, g0, g1, exp_rv;
    int   m_acc = 0;
    logic [2:0]  m_op = 3'd0;
    logic [15:0] m_a = 16'h0, m_b = 16'h0;
    always @(negedge clk) begin
        if (rst) begin
            check("req0_ready_in_rst", {31'd0, bus.req0_ready}, 0);
            check("req1_ready_in_rst", {31'd0, bus.req1_ready}, 0);
            m_idle = 1'b1; m_rr = 1'b0; m_op = 3'd0; m_a = 16'h0; m_b = 16'h0;
            exp_q.delete();
            post_rst = 1'b1;
        end else begin
            g0 = m_idle && bus.req0_valid && (!bus.req1_valid || !m_rr);
            g1 = m_idle && bus.req1_valid && (!bus.req0_valid || m_rr);
            exp_rv = !m_idle && cyc >= m_acc + LAT + 2;
            check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, g0});
            check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, g1});
            check("busy", {31'd0, bus.busy}, {31'd0, !m_idle});
            check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_rv});
            if (post_rst) begin
                check("rsp_data_after_rst", {16'd0, bus.rsp_data}, 0);
                check("rsp_id_after_rst", {31'd0, bus.rsp_id}, 0);
`ifdef INT_LOG_SCHED_ERR_EN
                check("rsp_err_after_rst", {31'd0, bus.rsp_err}, 0);
`endif
            end
            if (!m_idle || post_rst) begin
                check("dp_operation", {29'd0, bus.dp_operation}, {29'd0, m_op});
                check("dp_opa", {16'd0, bus.dp_opa}, {16'd0, m_a});
                check("dp_opb", {16'd0, bus.dp_opb}, {16'd0, m_b});
            end
            post_rst = 1'b0;
            if (exp_rv && bus.rsp_ready) m_idle = 1'b1;
            else if (g0 || g1) begin
                m_idle = 1'b0;
                m_acc = cyc;
                m_rr = g0;
                m_op = g1 ? bus.req1_op : bus.req0_op;
                m_a = g1 ? bus.req1_a : bus.req0_a;
                m_b = g1 ? bus.req1_b : bus.req0_b;
                exp_q.push_back(want(g1, m_op, m_a, m_b));
            end
        end
    end

    // Response monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected at cycle %0d: got data %h with no request outstanding", cyc, bus.rsp_data);
            end else begin
                check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, exp_q[0].data});
                check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, exp_q[0].id});
`ifdef INT_LOG_SCHED_ERR_EN
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_q[0].err});
`endif
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic v0, input logic [2:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                        input logic v1, input logic [2:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                        input logic rr_in);
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp_ready = rr_in;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
        bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        step(1, 3'd0, 16'hF0F0, 16'hFF00, 0, 0, 0, 0, 1);
        idle(6);
        rst = 1; idle(1); rst = 0;
        repeat (8) step(1, 3'd0, 16'hF0F0, 16'hFF00, 1, 3'd4, 16'hAAAA, 16'h5555, 0);
        step(0, 0, 0, 0, 1, 3'd4, 16'hAAAA, 16'h5555, 1);
        step(0, 0, 0, 0, 1, 3'd4, 16'hAAAA, 16'h5555, 1);
        idle(6);
        step(1, 3'd2, 16'h1111, 16'h2222, 0, 0, 0, 0, 1);
        idle(1);
        rst = 1; idle(1); rst = 0;
        step(0, 0, 0, 0, 1, 3'd6, 16'h1234, 16'h0000, 1);
        idle(6);
        step(1, 3'd7, 16'h1357, 16'h2468, 0, 0, 0, 0, 1);
        idle(6);
        step(1, 3'd3, 16'h0F0F, 16'h00FF, 0, 0, 0, 0, 1);
        idle(6);
        repeat (3000) begin
            rst = $urandom_range(0, 199) == 0;
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 2) != 0);
        end
        rst = 0;
        idle(20);
        check("drain_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/int_log_sched.md
INT_LOG_SCHED -- requirements
Module: int_log_sched

Interface
REQ-001 Parameter: LAT, 1, cycles from dp_* operands stable to dp_out valid; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid  input  1  (N=0,1) requester N offers an operation.
REQ-005 reqN_ready  output  1  (N=0,1) scheduler accepts requester N this cycle.
REQ-006 reqN_op  input  3  (N=0,1) logic opcode: 000 and, 001 nand, 010 or, 011 nor, 100 xor, 101 xnor, 110 not A, 111 undefined.
REQ-007 reqN_a, reqN_b  input  16 each  (N=0,1) operands A and B.
REQ-008 dp_operation  output  3  opcode to the shared 16-bit logic unit.
REQ-009 dp_opa, dp_opb  output  16 each  operands to the logic unit.
REQ-010 dp_out  input  16  logic unit result.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumer accepts.
REQ-013 rsp_data  output  16  captured result.
REQ-014 rsp_id  output  1  index of the requester that issued the operation.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 States SHALL be IDLE, WAIT, RESP; exactly one operation in flight.
REQ-017 IDLE: if any reqN_valid, grant one, assert its reqN_ready combinationally in that cycle only, latch op/a/b/id, load cnt=LAT, go WAIT.
REQ-018 Arbitration: single valid requester always granted; both valid -> requester selected by round-robin pointer rr; rr SHALL toggle to the non-granted index on each grant.
REQ-019 reqN_ready SHALL be low in WAIT and RESP and for the non-granted requester; valid may drop before acceptance without effect.
REQ-020 dp_operation/dp_opa/dp_opb SHALL be driven from the latched registers and held stable from the cycle after acceptance until return to IDLE.
REQ-021 WAIT: cnt decrements each cycle; when cnt==0, capture dp_out into rsp_data, go RESP (WAIT lasts LAT+1 cycles).
REQ-022 Latency: accept at cycle T -> rsp_valid first high at T+LAT+2 (T+3 for LAT=1).
REQ-023 RESP: rsp_valid high, rsp_data/rsp_id stable until rsp_valid&rsp_ready; then go IDLE; no new grant in the cycle of the handshake.
REQ-024 rsp_ready ignored outside RESP; held-high rsp_ready SHALL not shorten latency.
REQ-025 Back-to-back: earliest next acceptance is the cycle after the response handshake.

Reset
REQ-026 rst high at a clock edge SHALL force IDLE, rr=0 (requester 0 wins first tie), cnt=0, all outputs 0 (reqN_ready, rsp_valid, rsp_data, rsp_id, busy, dp_*).
REQ-027 Reset mid-operation SHALL abandon the in-flight operation with no response; rst dominates simultaneous valid/ready.

Configuration
REQ-028 Macro INT_LOG_SCHED_ERR_EN: when defined, output rsp_err (1 bit, reset 0) SHALL exist; opcode 111 completes with identical latency, rsp_err=1, rsp_data=16'h0000; rsp_err=0 for other opcodes.
REQ-029 Without INT_LOG_SCHED_ERR_EN: no rsp_err port; opcode 111 forwarded unchanged and rsp_data=dp_out as captured.

Verification
REQ-030 Reset, then req0 op=000 a=F0F0 b=FF00 -> dp_operation=000, rsp_valid at T+3, rsp_data=F000, rsp_id=0.
REQ-031 req0 and req1 valid same cycle after reset (req1 op=100 a=AAAA b=5555) -> req0 granted first; req1 granted after handshake, rsp_data=FFFF, rsp_id=1.
REQ-032 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable; req0/req1 ready low throughout.
REQ-033 rst asserted during WAIT -> next cycle busy=0, rsp_valid=0; subsequent op=110 a=1234 -> rsp_data=EDCB.
REQ-034 op=111 with INT_LOG_SCHED_ERR_EN -> rsp_err=1, rsp_data=0000; op=011 a=0F0F b=00FF -> rsp_err=0, rsp_data=F000.
